ef_i2s_dma_ctrl: RTL and testbench

//  Drains the EF_I2S receive FIFO into a circular memory buffer over a simple valid/ready write port.

---
 rtl/ef_i2s_dma_ctrl_pkg.sv | 17 +
 rtl/ef_i2s_dma_ctrl_if.sv | 16 +
 rtl/ef_i2s_dma_ctrl_ring_idx.sv | 52 +++++
 rtl/ef_i2s_dma_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ef_i2s_dma_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ef_i2s_dma_ctrl_pkg.sv
// Shared definitions for the EF_I2S receive-DMA controller.
//   state_e   : controller FSM states
//   SampleW   : width of one audio sample / bus word
//   WordBytes : bytes per bus word (ring stride)
package ef_i2s_dma_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StBurst,
    StFlush
  } state_e;

  localparam int unsigned SampleW   = 32;
  localparam int unsigned WordBytes = 4;

endpackage

// File: rtl/ef_i2s_dma_ctrl_if.sv
// Valid/ready write port from the DMA controller to the bus master adapter.
//   valid : write request valid (held until accepted)
//   addr  : byte address of the write
//   data  : write data
//   ready : adapter accepts the write when valid & ready
interface ef_i2s_dma_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              valid;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data;
  logic              ready;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/ef_i2s_dma_ctrl_ring_idx.sv
// Ring-buffer word index: modulo counter plus half/wrap position detect.
//   clk, rst_n : clock, async active-low reset
//   clr        : sync clear of the index
//   step       : advance the index by one word
//   buf_words  : ring length in words (0 treated as 1)
//   idx        : current word index
//   at_half    : idx is the last word of the first half (only when length >= 2)
//   at_wrap    : idx is the last word of the ring
module ef_i2s_dma_ctrl_ring_idx #(
  parameter int unsigned IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  input  logic [IDX_W-1:0] buf_words,
  output logic [IDX_W-1:0] idx,
  output logic             at_half,
  output logic             at_wrap
);

  localparam logic [IDX_W-1:0] One = IDX_W'(1);
  localparam logic [IDX_W-1:0] Two = IDX_W'(2);

  logic [IDX_W-1:0] len;
  logic [IDX_W-1:0] idx_q, idx_d;

  assign len = (buf_words == '0) ? One : buf_words;

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (step) begin
      // >= keeps the index inside the ring even if the length shrank
      idx_d = (idx_q >= len - One) ? '0 : idx_q + One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx     = idx_q;
  assign at_half = (len >= Two) && (idx_q == (len >> 1) - One);
  assign at_wrap = (idx_q == len - One);

endmodule

// File: rtl/ef_i2s_dma_ctrl.sv
// EF_I2S receive-FIFO to circular-buffer DMA controller.
//   clk, rst_n       : clock, async active-low reset
//   en, clr          : enable; sync clear (idx, overrun, state)
//   base_addr        : ring byte base (bits [1:0] ignored)
//   buf_words        : ring length in words (0 -> 1)
//   burst_len        : burst size / level trigger (0 -> 1)
//   timeout          : idle cycles before partial flush (0 = off)
//   fifo_*           : EF_I2S FIFO status, data and read strobe
//   m                : valid/ready write port (master side)
//   wr_idx, busy     : next ring index, state != IDLE
//   half_irq/wrap_irq: 1-cycle pulses after the half/last ring word is accepted
//   overrun          : sticky FIFO-full-while-enabled flag
module ef_i2s_dma_ctrl
  import ef_i2s_dma_ctrl_pkg::*;
#(
  parameter int unsigned AW     = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 16,
  parameter int unsigned TO_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [IDX_W-1:0]          buf_words,
  input  logic [AW-1:0]             burst_len,
  input  logic [TO_W-1:0]           timeout,
  input  logic                      fifo_empty,
  input  logic                      fifo_full,
  input  logic [AW-1:0]             fifo_level,
  input  logic [SampleW-1:0]        fifo_rdata,
  output logic                      fifo_rd,
  ef_i2s_dma_ctrl_if.master         m,
  output logic [IDX_W-1:0]          wr_idx,
  output logic                      busy,
  output logic                      half_irq,
  output logic                      wrap_irq,
  output logic                      overrun
);

  state_e              state_q, state_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic [AW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [AW-1:0]       blen;
  logic                valid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [SampleW-1:0]  data_q;
  logic                beat_half_q, beat_wrap_q;
  logic                half_q, wrap_q, overrun_q;
  logic                can_issue, fetch, accept, at_half, at_wrap;
  logic [IDX_W-1:0]    idx;
  logic [ADDR_W-1:0]   word_base;
  logic                unused_base;

  assign blen      = (burst_len == '0) ? AW'(1) : burst_len;
  assign word_base = {base_addr[ADDR_W-1:2], 2'b00};
  assign unused_base = ^base_addr[1:0];

  // No beat outstanding after this edge: slot empty or being accepted now
  assign can_issue = !valid_q || m.ready;
  assign fetch     = en && !clr && !fifo_empty && can_issue &&
                     (state_q == StBurst || state_q == StFlush);
  assign accept    = valid_q && m.ready && !clr;

  ef_i2s_dma_ctrl_ring_idx #(
    .IDX_W (IDX_W)
  ) u_ring_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .step      (fetch),
    .buf_words (buf_words),
    .idx       (idx),
    .at_half   (at_half),
    .at_wrap   (at_wrap)
  );

  always_comb begin
    state_d    = state_q;
    to_cnt_d   = '0;
    beat_cnt_d = '0;

    if (state_q == StWait && !fifo_empty) begin
      to_cnt_d = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1);
    end
    if (state_q == StBurst) begin
      beat_cnt_d = fetch ? beat_cnt_q + AW'(1) : beat_cnt_q;
    end

    if (clr) begin
      state_d  = StIdle;
      to_cnt_d = '0;
      beat_cnt_d = '0;
    end else if (!en) begin
      if (can_issue) state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: state_d = StWait;
        StWait: begin
          // fifo_level aliases to 0 when the FIFO is completely full
          if (fifo_full || fifo_level >= blen) begin
            state_d = StBurst;
          end else if (timeout != '0 && !fifo_empty && to_cnt_q >= timeout) begin
            state_d = StFlush;
          end
        end
        StBurst: begin
          if (fetch && beat_cnt_q == blen - AW'(1)) state_d = StWait;
        end
        StFlush: begin
          if (fifo_empty) state_d = StWait;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      to_cnt_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      beat_half_q <= 1'b0;
      beat_wrap_q <= 1'b0;
      half_q      <= 1'b0;
      wrap_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      half_q <= accept && beat_half_q;
      wrap_q <= accept && beat_wrap_q;
      if (clr) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        if (en && fifo_full) overrun_q <= 1'b1;
        if (fetch) begin
          valid_q     <= 1'b1;
          addr_q      <= word_base + ADDR_W'(idx) * ADDR_W'(WordBytes);
          data_q      <= fifo_rdata;
          beat_half_q <= at_half;
          beat_wrap_q <= at_wrap;
        end else if (m.ready) begin
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign fifo_rd  = fetch;
  assign m.valid  = valid_q;
  assign m.addr   = addr_q;
  assign m.data   = data_q;
  assign wr_idx   = idx;
  assign busy     = (state_q != StIdle);
  assign half_irq = half_q;
  assign wrap_irq = wrap_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_ef_i2s_dma_ctrl.sv
// Self-checking bench for ef_i2s_dma_ctrl: a behavioural 16-deep FIFO feeds the DUT,
// a monitor logs accepted beats and irq pulses, and a vector table plus a few
// hand-written sequences compare against hand-computed expectations.
module tb_ef_i2s_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] buf_words = '0;
  logic [3:0]  burst_len = '0;
  logic [15:0] timeout = '0;
  logic        fifo_empty, fifo_full, fifo_rd;
  logic [3:0]  fifo_level;
  logic [31:0] fifo_rdata;
  logic [15:0] wr_idx;
  logic        busy, half_irq, wrap_irq, overrun;

  ef_i2s_dma_ctrl_if #(.ADDR_W(32)) m_if ();

  ef_i2s_dma_ctrl #(
    .AW     (4),
    .ADDR_W (32),
    .IDX_W  (16),
    .TO_W   (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .base_addr  (base_addr),
    .buf_words  (buf_words),
    .burst_len  (burst_len),
    .timeout    (timeout),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_level (fifo_level),
    .fifo_rdata (fifo_rdata),
    .fifo_rd    (fifo_rd),
    .m          (m_if),
    .wr_idx     (wr_idx),
    .busy       (busy),
    .half_irq   (half_irq),
    .wrap_irq   (wrap_irq),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // FIFO model: pushes from the stimulus process, pops on fifo_rd at the clock edge
  logic [31:0] mem [16];
  int push_cnt = 0;
  int pop_cnt  = 0;
  int fifo_cnt;
  assign fifo_cnt   = push_cnt - pop_cnt;
  assign fifo_empty = (fifo_cnt == 0);
  assign fifo_full  = (fifo_cnt == 16);
  assign fifo_level = fifo_cnt[3:0];
  assign fifo_rdata = mem[pop_cnt[3:0]];

  // Monitor
  int rd_cnt = 0;
  int acc_cnt = 0;
  int half_cnt = 0;
  int wrap_cnt = 0;
  logic [31:0] log_addr [256];
  logic [31:0] log_data [256];

  always @(posedge clk) begin
    if (fifo_rd) begin
      pop_cnt <= pop_cnt + 1;
      rd_cnt  <= rd_cnt + 1;
    end
    if (m_if.valid && m_if.ready) begin
      log_addr[acc_cnt[7:0]] <= m_if.addr;
      log_data[acc_cnt[7:0]] <= m_if.data;
      acc_cnt <= acc_cnt + 1;
    end
    if (half_irq) half_cnt <= half_cnt + 1;
    if (wrap_irq) wrap_cnt <= wrap_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pat(input int g);
    return 32'hC0DE_0000 | 32'(g);
  endfunction

  task automatic push();
    mem[push_cnt[3:0]] = pat(push_cnt);
    push_cnt = push_cnt + 1;
    step();
  endtask

  task automatic do_clr();
    en  = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
  endtask

  task automatic wait_acc(input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!m_if.valid && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic check_beats(input int g0, input int n, input logic [31:0] base, input int bwe);
    logic [31:0] wb;
    wb = {base[31:2], 2'b00};
    for (int k = 0; k < n; k++) begin
      chk($sformatf("addr[%0d]", g0 + k), log_addr[(g0 + k) % 256], wb + 32'(4 * (k % bwe)));
      chk($sformatf("data[%0d]", g0 + k), log_data[(g0 + k) % 256], pat(g0 + k));
    end
  endtask

  typedef struct {
    logic [31:0] base;
    int bw;
    int bl;
    int np;
    int to;
    int beats;
    int idx;
    int half;
    int wrap;
  } vec_t;

  vec_t vec [6];

  initial begin
    int g0, h0, w0, r0;
    vec_t r;

    //          base           bw bl np  to beats idx half wrap
    vec[0] = '{32'h1000_0000, 8, 4, 4,  0,  4,   4,  1,   0};
    vec[1] = '{32'h2000_0010, 8, 4, 2,  10, 2,   2,  0,   0};
    vec[2] = '{32'h3000_0003, 3, 2, 4,  0,  4,   1,  2,   1};
    vec[3] = '{32'h4000_0100, 0, 0, 3,  0,  3,   0,  0,   3};
    vec[4] = '{32'h5000_0000, 5, 3, 5,  6,  5,   0,  1,   1};
    vec[5] = '{32'h6000_0020, 8, 4, 16, 0,  16,  0,  2,   2};

    m_if.ready = 1'b0;
    step();
    step();
    chk("rst_fifo_rd", 32'(fifo_rd), 0);
    chk("rst_m_valid", 32'(m_if.valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wr_idx", 32'(wr_idx), 0);
    chk("rst_irq", 32'({half_irq, wrap_irq}), 0);
    chk("rst_overrun", 32'(overrun), 0);
    rst_n = 1'b1;
    step();

    // Table-driven transfers
    for (int v = 0; v < 6; v++) begin
      r = vec[v];
      do_clr();
      base_addr  = r.base;
      buf_words  = 16'(r.bw);
      burst_len  = 4'(r.bl);
      timeout    = 16'(r.to);
      m_if.ready = 1'b1;
      g0 = acc_cnt;
      h0 = half_cnt;
      w0 = wrap_cnt;
      en = 1'b1;
      for (int i = 0; i < r.np; i++) push();
      wait_acc(g0 + r.beats, 400);
      repeat (30) step();
      chk($sformatf("v%0d_beats", v), 32'(acc_cnt - g0), 32'(r.beats));
      chk($sformatf("v%0d_wr_idx", v), 32'(wr_idx), 32'(r.idx));
      chk($sformatf("v%0d_half", v), 32'(half_cnt - h0), 32'(r.half));
      chk($sformatf("v%0d_wrap", v), 32'(wrap_cnt - w0), 32'(r.wrap));
      chk($sformatf("v%0d_busy", v), 32'(busy), 1);
      check_beats(g0, r.beats, r.base, (r.bw == 0) ? 1 : r.bw);
    end

    // Back-pressure: beat held stable, no extra FIFO reads
    do_clr();
    base_addr = 32'h7000_0000;
    buf_words = 16'd8;
    burst_len = 4'd4;
    timeout   = 16'd0;
    m_if.ready = 1'b0;
    g0 = acc_cnt;
    r0 = rd_cnt;
    en = 1'b1;
    for (int i = 0; i < 4; i++) push();
    wait_valid(50);
    chk("stall_valid", 32'(m_if.valid), 1);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_hold_valid", 32'(m_if.valid), 1);
      chk("stall_hold_addr", m_if.addr, 32'h7000_0000);
      chk("stall_hold_data", m_if.data, pat(g0));
    end
    chk("stall_rd", 32'(rd_cnt - r0), 1);
    chk("stall_acc", 32'(acc_cnt - g0), 0);
    m_if.ready = 1'b1;
    wait_acc(g0 + 4, 100);
    repeat (10) step();
    chk("stall_beats", 32'(acc_cnt - g0), 4);
    check_beats(g0, 4, 32'h7000_0000, 8);

    // Overrun: fill FIFO while disabled, then enable
    do_clr();
    base_addr = 32'h9000_0000;
    g0 = acc_cnt;
    for (int i = 0; i < 16; i++) push();
    chk("ovr_full", 32'(fifo_full), 1);
    chk("ovr_en_low", 32'(overrun), 0);
    en = 1'b1;
    step();
    chk("ovr_set", 32'(overrun), 1);
    wait_acc(g0 + 16, 200);
    repeat (20) step();
    chk("ovr_beats", 32'(acc_cnt - g0), 16);
    chk("ovr_wr_idx", 32'(wr_idx), 0);
    chk("ovr_sticky", 32'(overrun), 1);
    check_beats(g0, 16, 32'h9000_0000, 8);
    do_clr();
    chk("ovr_clr", 32'(overrun), 0);
    chk("clr_busy", 32'(busy), 0);

    // Enable dropped mid-burst while the beat is stalled
    base_addr = 32'h8000_0000;
    m_if.ready = 1'b0;
    g0 = acc_cnt;
    r0 = rd_cnt;
    en = 1'b1;
    for (int i = 0; i < 4; i++) push();
    wait_valid(50);
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("endrop_valid", 32'(m_if.valid), 1);
      chk("endrop_busy", 32'(busy), 1);
    end
    m_if.ready = 1'b1;
    step();
    m_if.ready = 1'b0;
    step();
    chk("endrop_idle", 32'(busy), 0);
    chk("endrop_valid_low", 32'(m_if.valid), 0);
    chk("endrop_acc", 32'(acc_cnt - g0), 1);
    chk("endrop_rd", 32'(rd_cnt - r0), 1);
    burst_len  = 4'd1;
    m_if.ready = 1'b1;
    en = 1'b1;
    wait_acc(g0 + 4, 100);
    repeat (10) step();
    chk("endrop_drain", 32'(acc_cnt - g0), 4);
    check_beats(g0, 4, 32'h8000_0000, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
